// File: rtl/vga_timing_gen_pkg.sv
// Shared constants, types and helpers for the VGA raster timing generator.
package vga_timing_gen_pkg;

  localparam int unsigned CNT_W     = 12;
  localparam int unsigned MAX_TOTAL = 4096;

  // Standard 640x480@60 timing set.
  localparam int unsigned VGA640_H_VIS  = 640;
  localparam int unsigned VGA640_H_FP   = 16;
  localparam int unsigned VGA640_H_SYNC = 96;
  localparam int unsigned VGA640_H_BP   = 48;
  localparam int unsigned VGA640_V_VIS  = 480;
  localparam int unsigned VGA640_V_FP   = 10;
  localparam int unsigned VGA640_V_SYNC = 2;
  localparam int unsigned VGA640_V_BP   = 33;

  typedef enum logic [1:0] {StIdle, StWait, StGrant, StRevoke} grant_state_e;

  function automatic int unsigned axis_total(input int unsigned vis, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return vis + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: master is the generator, slave is the video/host consumer.
interface vga_timing_gen_if;
  import vga_timing_gen_pkg::*;

  logic             hostReq;
  logic             hostGrant;
  logic [CNT_W-1:0] hCount;
  logic [CNT_W-1:0] vCount;
  logic             hSync;
  logic             vSync;
  logic             vis;
  logic             frameStart;
  logic [7:0]       charCol;
  logic [7:0]       charRow;
  logic [3:0]       glyphCol;
  logic [3:0]       glyphRow;
  logic             prefetch;

  modport master (
    input  hostReq,
    output hostGrant, hCount, vCount, hSync, vSync, vis, frameStart,
           charCol, charRow, glyphCol, glyphRow, prefetch
  );

  modport slave (
    output hostReq,
    input  hostGrant, hCount, vCount, hSync, vSync, vis, frameStart,
           charCol, charRow, glyphCol, glyphRow, prefetch
  );

endinterface

// File: rtl/vga_timing_gen_axis.sv
// One raster axis: wrapping counter, visible/sync decode and a one-clock delayed output stage.
module vga_axis_counter
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned TOTAL      = 800,
  parameter int unsigned VIS        = 640,
  parameter int unsigned SYNC_START = 656,
  parameter int unsigned SYNC_LEN   = 96,
  parameter bit          POL        = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_wrap,
  output logic             o_vis,
  output logic [CNT_W-1:0] o_pos,
  output logic             o_sync
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_pos;
  logic             r_sync;
  logic             w_in_sync;

  assign o_cnt     = r_cnt;
  assign o_wrap    = i_en && (r_cnt == CNT_W'(TOTAL - 1));
  assign o_vis     = 32'(r_cnt) < VIS;
  assign w_in_sync = (32'(r_cnt) >= SYNC_START) && (32'(r_cnt) < SYNC_START + SYNC_LEN);
  assign o_pos     = r_pos;
  assign o_sync    = r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_pos  <= '0;
      r_sync <= ~POL;
    end else begin
      if (i_en) begin
        r_cnt <= o_wrap ? '0 : r_cnt + CNT_W'(1);
      end
      r_pos  <= r_cnt;
      r_sync <= w_in_sync ? POL : ~POL;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with character coordinates, readout
// prefetch window and a vertical-blank VRAM grant for the host.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned H_VIS     = VGA640_H_VIS,
  parameter int unsigned H_FP      = VGA640_H_FP,
  parameter int unsigned H_SYNC    = VGA640_H_SYNC,
  parameter int unsigned H_BP      = VGA640_H_BP,
  parameter int unsigned V_VIS     = VGA640_V_VIS,
  parameter int unsigned V_FP      = VGA640_V_FP,
  parameter int unsigned V_SYNC    = VGA640_V_SYNC,
  parameter int unsigned V_BP      = VGA640_V_BP,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned CHAR_W    = 8,
  parameter int unsigned CHAR_H    = 16,
  parameter int unsigned PREFETCH  = 3
) (
  input  logic              clk,
  input  logic              rst,
  vga_timing_gen_if.master  o_vga
);

  localparam int unsigned H_TOTAL = axis_total(H_VIS, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = axis_total(V_VIS, V_FP, V_SYNC, V_BP);
  localparam int unsigned CW_LOG2 = $clog2(CHAR_W);

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_check
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 4096");
  end

  logic [CNT_W-1:0] w_h, w_v, w_h_pos, w_v_pos;
  logic             w_h_wrap, w_v_wrap, w_h_vis, w_v_vis, w_hsync, w_vsync;
  logic             w_vis, w_next_vis, w_pf;
  logic [3:0]       r_glyph_cnt;
  logic [7:0]       r_char_cnt;
  logic             r_vis, r_frame, r_pf;
  logic [7:0]       r_char_col, r_char_row;
  logic [3:0]       r_glyph_col, r_glyph_row;
  grant_state_e     r_state;

  vga_axis_counter #(
    .TOTAL(H_TOTAL), .VIS(H_VIS), .SYNC_START(H_VIS + H_FP), .SYNC_LEN(H_SYNC), .POL(HSYNC_POL)
  ) u_h_axis (
    .clk(clk), .rst(rst), .i_en(1'b1), .o_cnt(w_h), .o_wrap(w_h_wrap), .o_vis(w_h_vis),
    .o_pos(w_h_pos), .o_sync(w_hsync)
  );

  vga_axis_counter #(
    .TOTAL(V_TOTAL), .VIS(V_VIS), .SYNC_START(V_VIS + V_FP), .SYNC_LEN(V_SYNC), .POL(VSYNC_POL)
  ) u_v_axis (
    .clk(clk), .rst(rst), .i_en(w_h_wrap), .o_cnt(w_v), .o_wrap(w_v_wrap), .o_vis(w_v_vis),
    .o_pos(w_v_pos), .o_sync(w_vsync)
  );

  assign w_vis      = w_h_vis && w_v_vis;
  // Line V_TOTAL-1 fetches ahead for line 0 of the next frame.
  assign w_next_vis = (w_v == CNT_W'(V_TOTAL - 1)) || (32'(w_v) + 32'd1 < V_VIS);
  assign w_pf       = ((32'(w_h) >= H_TOTAL - PREFETCH) && w_next_vis) ||
                      ((32'(w_h) < H_VIS - PREFETCH) && w_v_vis);

  // Glyph/char row counters track the internal line, CHAR_H need not be a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_glyph_cnt <= '0;
      r_char_cnt  <= '0;
    end else if (w_v_wrap) begin
      r_glyph_cnt <= '0;
      r_char_cnt  <= '0;
    end else if (w_h_wrap && w_v_vis) begin
      if (r_glyph_cnt == 4'(CHAR_H - 1)) begin
        r_glyph_cnt <= '0;
        r_char_cnt  <= r_char_cnt + 8'd1;
      end else begin
        r_glyph_cnt <= r_glyph_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vis       <= 1'b0;
      r_frame     <= 1'b0;
      r_pf        <= 1'b0;
      r_char_col  <= '0;
      r_char_row  <= '0;
      r_glyph_col <= '0;
      r_glyph_row <= '0;
    end else begin
      r_vis       <= w_vis;
      r_frame     <= (w_h == '0) && (w_v == '0);
      r_pf        <= w_pf;
      r_char_col  <= w_vis ? 8'(w_h >> CW_LOG2) : 8'd0;
      r_glyph_col <= w_vis ? 4'(w_h & CNT_W'(CHAR_W - 1)) : 4'd0;
      r_char_row  <= w_vis ? r_char_cnt : 8'd0;
      r_glyph_row <= w_vis ? r_glyph_cnt : 4'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      unique case (r_state)
        StIdle:   if (o_vga.hostReq) r_state <= StWait;
        StWait: begin
          if (!o_vga.hostReq) begin
            r_state <= StIdle;
          end else if (32'(w_v) >= V_VIS && 32'(w_v) < V_TOTAL - 1) begin
            r_state <= StGrant;
          end
        end
        StGrant: begin
          if (!o_vga.hostReq) begin
            r_state <= StIdle;
          end else if (w_v == CNT_W'(V_TOTAL - 1) && w_h == '0) begin
            r_state <= StRevoke;
          end
        end
        StRevoke: if (!o_vga.hostReq) r_state <= StIdle;
        default:  r_state <= StIdle;
      endcase
    end
  end

  assign o_vga.hostGrant  = (r_state == StGrant);
  assign o_vga.hCount     = w_h_pos;
  assign o_vga.vCount     = w_v_pos;
  assign o_vga.hSync      = w_hsync;
  assign o_vga.vSync      = w_vsync;
  assign o_vga.vis        = r_vis;
  assign o_vga.frameStart = r_frame;
  assign o_vga.charCol    = r_char_col;
  assign o_vga.charRow    = r_char_row;
  assign o_vga.glyphCol   = r_glyph_col;
  assign o_vga.glyphRow   = r_glyph_row;
  assign o_vga.prefetch   = r_pf;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: per-cycle raster model plus directed literal checks.
module tb_vga_timing_gen;

  localparam int HV = 16, HF = 2, HS = 4, HB = 2, HT = 24;
  localparam int VV = 8, VF = 1, VS = 2, VB = 1, VT = 12;
  localparam int CW = 4, CH = 4, PF = 2;
  localparam int F = HT * VT;

  logic clk;
  logic rst;
  int   n_total = 0;
  int   n_bad   = 0;
  int   m_k;
  int   m_st;

  vga_timing_gen_if vif ();

  vga_timing_gen #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
    .CHAR_W(CW), .CHAR_H(CH), .PREFETCH(PF)
  ) dut (
    .clk(clk), .rst(rst), .o_vga(vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0d required %0d (t=%0t h=%0d v=%0d)", name, act, exp, $time,
                 vif.hCount, vif.vCount);
    end
  endtask

  // Host grant rules applied to the internal raster position ip.
  function automatic int grant_next(input int st, input bit req, input int ip);
    int h, v;
    h = ip % HT;
    v = ip / HT;
    case (st)
      0: return req ? 1 : 0;
      1: return !req ? 0 : ((v >= VV && v < VT - 1) ? 2 : 1);
      2: return !req ? 0 : ((v == VT - 1 && h == 0) ? 3 : 2);
      default: return req ? 3 : 0;
    endcase
  endfunction

  // m_k = rising edges since reset; outputs after m_k edges show raster position m_k-1.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_k  <= 0;
      m_st <= 0;
    end else begin
      m_st <= grant_next(m_st, vif.hostReq, m_k % F);
      m_k  <= m_k + 1;
    end
  end

  function automatic bit vis_at(input int p);
    return ((p % HT) < HV) && ((p / HT) < VV);
  endfunction

  always @(negedge clk) begin
    int p, h, v;
    bit vi, run;
    run = (m_k != 0);
    p   = run ? (m_k - 1) % F : 0;
    h   = p % HT;
    v   = p / HT;
    vi  = run && vis_at(p);
    check("hCount", int'(vif.hCount), h);
    check("vCount", int'(vif.vCount), v);
    check("hSync", int'(vif.hSync), (run && h >= HV + HF && h < HV + HF + HS) ? 0 : 1);
    check("vSync", int'(vif.vSync), (run && v >= VV + VF && v < VV + VF + VS) ? 0 : 1);
    check("vis", int'(vif.vis), int'(vi));
    check("frameStart", int'(vif.frameStart), (run && p == 0) ? 1 : 0);
    check("charCol", int'(vif.charCol), vi ? h / CW : 0);
    check("glyphCol", int'(vif.glyphCol), vi ? h % CW : 0);
    check("charRow", int'(vif.charRow), vi ? v / CH : 0);
    check("glyphRow", int'(vif.glyphRow), vi ? v % CH : 0);
    // Prefetch at p means the pixel PF clocks later is visible.
    check("prefetch", int'(vif.prefetch), (run && vis_at((p + PF) % F)) ? 1 : 0);
    check("hostGrant", int'(vif.hostGrant), (m_st == 2) ? 1 : 0);
  end

  task automatic wait_for(input int h, input int v);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 2 * F && !hit; i++) begin
      if (int'(vif.hCount) == h && int'(vif.vCount) == v) hit = 1'b1;
      else @(negedge clk);
    end
    if (!hit) check("wait_timeout", 0, 1);
  endtask

  initial begin
    int cyc, n_vis, n_pf, n_hs, n_vs;
    bit hit;
    rst         = 1'b1;
    vif.hostReq = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;

    // 1: frame period and per-frame counts
    hit = 1'b0;
    for (int i = 0; i < 5 && !hit; i++) begin
      @(negedge clk);
      hit = vif.frameStart;
    end
    check("first_frameStart", int'(hit), 1);
    check("first_frame_pos", int'(vif.hCount) + int'(vif.vCount), 0);
    cyc = 0; n_vis = 0; n_pf = 0; n_hs = 0; n_vs = 0; hit = 1'b0;
    while (!hit && cyc < 1000) begin
      n_vis += int'(vif.vis);
      n_pf  += int'(vif.prefetch);
      n_hs  += int'(!vif.hSync);
      n_vs  += int'(!vif.vSync);
      @(negedge clk);
      cyc++;
      hit = vif.frameStart;
    end
    check("frame_period", cyc, 288);
    check("vis_per_frame", n_vis, 128);
    check("pf_per_frame", n_pf, 128);
    check("hsync_low_per_frame", n_hs, 48);
    check("vsync_low_per_frame", n_vs, 48);

    // 2/3: character coordinates and prefetch window
    wait_for(13, 0);
    check("pf_0_13", int'(vif.prefetch), 1);
    wait_for(14, 0);
    check("pf_0_14", int'(vif.prefetch), 0);
    wait_for(13, 6);
    check("charCol_13_6", int'(vif.charCol), 3);
    check("glyphCol_13_6", int'(vif.glyphCol), 1);
    check("charRow_13_6", int'(vif.charRow), 1);
    check("glyphRow_13_6", int'(vif.glyphRow), 2);
    wait_for(16, 6);
    check("coords_zero_16_6", int'(vif.charCol) + int'(vif.glyphCol) + int'(vif.charRow) +
          int'(vif.glyphRow), 0);
    wait_for(22, 7);
    check("pf_7_22", int'(vif.prefetch), 0);
    wait_for(5, 9);
    check("pf_9_5", int'(vif.prefetch), 0);
    wait_for(21, 11);
    check("pf_11_21", int'(vif.prefetch), 0);
    wait_for(22, 11);
    check("pf_11_22", int'(vif.prefetch), 1);

    // 4: request during visible area, grant over vblank, revoke held
    wait_for(0, 3);
    vif.hostReq = 1'b1;
    wait_for(23, 7);
    check("grant_7_23", int'(vif.hostGrant), 0);
    @(negedge clk);
    check("grant_rise_v", int'(vif.vCount), 8);
    check("grant_8_0", int'(vif.hostGrant), 1);
    wait_for(23, 10);
    check("grant_10_23", int'(vif.hostGrant), 1);
    @(negedge clk);
    check("grant_11_0", int'(vif.hostGrant), 0);
    wait_for(0, 9);
    check("revoke_held_9_0", int'(vif.hostGrant), 0);
    wait_for(1, 9);
    vif.hostReq = 1'b0;
    @(negedge clk);

    // 5: short request inside vblank
    wait_for(10, 9);
    vif.hostReq = 1'b1;
    @(negedge clk);
    check("grant_wait", int'(vif.hostGrant), 0);
    @(negedge clk);
    check("grant_vblank", int'(vif.hostGrant), 1);
    wait_for(0, 10);
    vif.hostReq = 1'b0;
    check("grant_before_drop", int'(vif.hostGrant), 1);
    @(negedge clk);
    check("grant_after_drop", int'(vif.hostGrant), 0);

    // 6: async reset mid-frame
    wait_for(7, 5);
    #2 rst = 1'b1;
    #1;
    check("rst_hCount", int'(vif.hCount), 0);
    check("rst_vCount", int'(vif.vCount), 0);
    check("rst_hSync", int'(vif.hSync), 1);
    check("rst_vSync", int'(vif.vSync), 1);
    check("rst_vis", int'(vif.vis), 0);
    check("rst_prefetch", int'(vif.prefetch), 0);
    check("rst_glyphCol", int'(vif.glyphCol), 0);
    check("rst_charRow", int'(vif.charRow), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("restart_frameStart", int'(vif.frameStart), 1);
    check("restart_h", int'(vif.hCount), 0);
    wait_for(18, 0);
    check("restart_hsync", int'(vif.hSync), 0);
    wait_for(0, 9);
    check("restart_vsync", int'(vif.vSync), 0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator that replaces the fixed-mode horizontal counter, vertical counter and sync blocks with one block for any resolution and sync polarity. It also supplies character-cell coordinates, a readout prefetch window for the text pipeline, and a vertical-blank VRAM access grant for the host side.

Parameters:
H_VIS, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_VIS, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, active level of hSync
VSYNC_POL, 0, active level of vSync
CHAR_W, 8, glyph width in pixels (power of two, 2..16)
CHAR_H, 16, glyph height in lines (2..16)
PREFETCH, 3, readout lead in clocks before each visible pixel (1..CHAR_W)

Ports:
clk  in  1  dot clock
rst  in  1  asynchronous reset, active-high
hostReq  in  1  host requests a VRAM access window (level)
hostGrant  out  1  host may access VRAM while high
hCount  out  12  horizontal position, 0..H_TOTAL-1
vCount  out  12  line number, 0..V_TOTAL-1
hSync  out  1  horizontal sync at HSYNC_POL level
vSync  out  1  vertical sync at VSYNC_POL level
vis  out  1  pixel at (hCount,vCount) is visible
frameStart  out  1  one-clock pulse at hCount=0, vCount=0
charCol  out  8  character column of the visible pixel
charRow  out  8  character row of the visible line
glyphCol  out  4  pixel column within the glyph
glyphRow  out  4  line within the glyph
prefetch  out  1  readout fetch window

Behaviour:
- H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP. V_TOTAL is defined the same way from the V_ parameters. Both must be <= 4096 (elaboration check).
- Internal counters: h increments every clock and wraps at H_TOTAL-1. v increments when h wraps and itself wraps at V_TOTAL-1.
- All outputs are registered decodes of the internal counters. Every output lags the internal counter by exactly one clock, and hCount/vCount are delayed by the same amount, so all outputs stay mutually aligned.
- hSync is at the active level when hCount is in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1]. vSync is at the active level when vCount is in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1], switching at the hCount=0 boundary.
- vis = (hCount < H_VIS) && (vCount < V_VIS).
- glyphCol = hCount mod CHAR_W. charCol = hCount / CHAR_W (shift). Both are forced to 0 outside the visible region.
- glyphRow/charRow: reset to 0 at vCount=0. glyphRow increments at each line wrap while vCount < V_VIS. When glyphRow is at CHAR_H-1 it wraps to 0 and charRow increments. A partial last character row is allowed.
- prefetch is high for exactly H_VIS clocks per visible line, starting PREFETCH clocks before the first visible pixel:
  - the tail of the previous line (h >= H_TOTAL-PREFETCH) counts when the next line is visible;
  - the current line (h < H_VIS-PREFETCH) counts when it is visible.
  - Line V_TOTAL-1 prefetches for line 0.
- Host grant FSM, states IDLE, WAIT, GRANT, REVOKE:
  - IDLE -> WAIT when hostReq=1.
  - WAIT -> GRANT when v >= V_VIS and v < V_TOTAL-1.
  - GRANT -> IDLE when hostReq=0.
  - GRANT -> REVOKE when v=V_TOTAL-1 and h=0.
  - REVOKE -> IDLE when hostReq=0.
  - hostGrant=1 only in GRANT and follows the state register with no extra lag.
  - A request present during the visible area waits; a grant never overlaps prefetch.
  - hostReq dropping while in WAIT returns the FSM to IDLE.
- Reset (async assert, sync release): counters 0, FSM IDLE. Output reset values: hSync=~HSYNC_POL, vSync=~VSYNC_POL, vis=0, frameStart=0, prefetch=0, hostGrant=0, hCount=vCount=charCol=charRow=glyphCol=glyphRow=0.
- Reset mid-frame restarts the raster at (0,0). First frameStart is issued one clock after reset release.

Decomposition:
- Shared package: H_TOTAL/V_TOTAL derivation function, 12-bit counter width constant, grant FSM state enum, and the standard 640x480@60 parameter set.
- One natural sub-module, vga_axis_counter: counter with wrap, visible/sync decode and a registered output stage. It is instantiated once for h and once for v, with v using the h-wrap as its increment enable.

Test Plan:
Use H_VIS=16, H_FP=2, H_SYNC=4, H_BP=2 (H_TOTAL=24), V_VIS=8, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=12), CHAR_W=4, CHAR_H=4, PREFETCH=2.
1. Release reset, run 2 frames -> frameStart every 288 clocks; hSync low for hCount 18..21; vSync low for vCount 9..10; vis for 128 pixels per frame.
2. Character coordinates -> at hCount=13, vCount=6: charCol=3, glyphCol=1, charRow=1, glyphRow=2; all four are 0 at hCount=16.
3. Prefetch -> high at internal h=22,23 of line 11 and at h=0..13 of line 0; exactly 16 clocks per visible line; low on lines 7->8 tail and on lines 8..10.
4. hostReq=1 at vCount=3 -> hostGrant rises at vCount=8, hCount=0 (+1 clock) and falls at vCount=11 start; REVOKE is held until hostReq=0.
5. hostReq pulsed high then low inside vertical blank -> grant lasts until the clock after hostReq falls; the FSM returns to IDLE.
6. Assert rst at vCount=5, hCount=7 -> all outputs at their reset values immediately (async); after release the raster restarts from (0,0) with correct sync.
